// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the compute-bus arbiter: requester counts and FSM state encoding.
package bus_arbiter_pkg;

  localparam int NUM_CIMS       = 64;
  localparam int NUM_REQ        = NUM_CIMS + 1;
  localparam int MASTER_REQ_IDX = 0;

  typedef enum logic [1:0] {
    ARB,
    OWN,
    TURN
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus requesters (master side) and the arbiter (slave side).
interface bus_arbiter_if #(
  parameter int NUM_REQ = bus_arbiter_pkg::NUM_REQ
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic               master_prio;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic               burst_expired;

  modport master (
    output req,
    output master_prio,
    input  grant,
    input  grant_id,
    input  grant_valid,
    input  burst_expired
  );

  modport slave (
    input  req,
    input  master_prio,
    output grant,
    output grant_id,
    output grant_valid,
    output burst_expired
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin winner search starting at rr_ptr, with optional master override.
module bus_arbiter_rr_picker #(
  parameter int NUM_REQ = bus_arbiter_pkg::NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  input  logic               master_prio_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               found_o
);

  import bus_arbiter_pkg::*;

  int idx;

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    // NUM_REQ is not a power of two, so the wrap is an explicit subtract.
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr_i) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = ID_W'(idx);
      end
    end
    if (master_prio_i && req_i[MASTER_REQ_IDX]) begin
      found_o  = 1'b1;
      winner_o = ID_W'(MASTER_REQ_IDX);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared master/CiM bus with burst limit and turnaround gap.
module bus_arbiter #(
  parameter int NUM_REQ    = bus_arbiter_pkg::NUM_REQ,
  parameter int MAX_BURST  = 64,
  parameter int TURNAROUND = 1
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus_if
);

  import bus_arbiter_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int TC_W = $clog2(TURNAROUND + 1);

  localparam logic [BC_W-1:0] BURST_LIMIT = BC_W'(MAX_BURST);
  localparam logic [TC_W-1:0] TURN_LOAD   = TC_W'(TURNAROUND);
  localparam logic [ID_W-1:0] LAST_IDX    = ID_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic               burst_expired_q, burst_expired_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [TC_W-1:0]    turn_cnt_q, turn_cnt_d;

  logic [ID_W-1:0]    winner;
  logic               found;
  logic               owner_req;

  bus_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i         (bus_if.req),
    .rr_ptr_i      (rr_ptr_q),
    .master_prio_i (bus_if.master_prio),
    .winner_o      (winner),
    .found_o       (found)
  );

  assign owner_req = |(bus_if.req & grant_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ARB;
      grant_q         <= '0;
      grant_id_q      <= '0;
      grant_valid_q   <= 1'b0;
      burst_expired_q <= 1'b0;
      rr_ptr_q        <= '0;
      burst_cnt_q     <= '0;
      turn_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      grant_id_q      <= grant_id_d;
      grant_valid_q   <= grant_valid_d;
      burst_expired_q <= burst_expired_d;
      rr_ptr_q        <= rr_ptr_d;
      burst_cnt_q     <= burst_cnt_d;
      turn_cnt_q      <= turn_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    grant_id_d      = grant_id_q;
    grant_valid_d   = grant_valid_q;
    burst_expired_d = 1'b0;
    rr_ptr_d        = rr_ptr_q;
    burst_cnt_d     = burst_cnt_q;
    turn_cnt_d      = turn_cnt_q;

    unique case (state_q)
      ARB: begin
        if (found) begin
          state_d          = OWN;
          grant_d          = '0;
          grant_d[winner]  = 1'b1;
          grant_id_d       = winner;
          grant_valid_d    = 1'b1;
          burst_cnt_d      = BC_W'(1);
          rr_ptr_d         = (winner == LAST_IDX) ? '0 : winner + ID_W'(1);
        end
      end
      OWN: begin
        if (owner_req && (burst_cnt_q < BURST_LIMIT)) begin
          burst_cnt_d = burst_cnt_q + BC_W'(1);
        end else begin
          // Still requesting here means the burst limit, not a release, ended the tenure.
          state_d         = TURN;
          grant_d         = '0;
          grant_id_d      = '0;
          grant_valid_d   = 1'b0;
          burst_expired_d = owner_req;
          burst_cnt_d     = '0;
          turn_cnt_d      = TURN_LOAD;
        end
      end
      TURN: begin
        if (turn_cnt_q == TC_W'(1)) begin
          state_d = ARB;
        end else begin
          turn_cnt_d = turn_cnt_q - TC_W'(1);
        end
      end
      default: begin
        state_d       = ARB;
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  assign bus_if.grant         = grant_q;
  assign bus_if.grant_id      = grant_id_q;
  assign bus_if.grant_valid   = grant_valid_q;
  assign bus_if.burst_expired = burst_expired_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random-exclusivity bench for bus_arbiter (65 requesters, burst 64, turnaround 1).
module tb_bus_arbiter;

  localparam int NREQ = 65;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter_if #(.NUM_REQ(NREQ)) bus_if ();

  bus_arbiter #(
    .NUM_REQ    (NREQ),
    .MAX_BURST  (64),
    .TURNAROUND (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int id);
    logic [NREQ-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  // Checks n owned cycles, releases on the last one, then checks the first idle cycle.
  task automatic own_cycles(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      chk("own_grant", 128'(bus_if.grant), 128'(oh(id)));
      chk("own_id", 128'(bus_if.grant_id), 128'(id));
      if (i == n - 1) bus_if.req[id] = 1'b0;
      tick();
    end
    chk("end_grant", 128'(bus_if.grant), 128'(0));
    chk("end_no_expire", 128'(bus_if.burst_expired), 128'(0));
  endtask

  task automatic next_tenure(input int id, input int n, input bit reraise);
    own_cycles(id, n);
    if (reraise) bus_if.req[id] = 1'b1;
    tick();
    chk("gap_grant", 128'(bus_if.grant), 128'(0));
    tick();
  endtask

  initial begin
    logic [NREQ-1:0] g, prev_g;
    int              exp_id, idle_run, run_len, k;
    bit              had_grant;

    bus_if.req         = '0;
    bus_if.master_prio = 1'b0;
    rst                = 1'b1;
    repeat (2) tick();
    chk("rst_grant", 128'(bus_if.grant), 128'(0));
    chk("rst_id", 128'(bus_if.grant_id), 128'(0));
    chk("rst_valid", 128'(bus_if.grant_valid), 128'(0));
    chk("rst_expired", 128'(bus_if.burst_expired), 128'(0));
    rst = 1'b0;
    tick();

    // Round-robin 1 -> 2 -> 5 -> 1
    bus_if.req[1] = 1'b1;
    bus_if.req[2] = 1'b1;
    bus_if.req[5] = 1'b1;
    tick();
    chk("rr_valid", 128'(bus_if.grant_valid), 128'(1));
    next_tenure(1, 1, 1'b1);
    next_tenure(2, 1, 1'b1);
    next_tenure(5, 1, 1'b1);
    own_cycles(1, 1);
    bus_if.req = '0;
    repeat (3) tick();

    // Burst limit on requester 3
    bus_if.req[3] = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      chk("burst_id", 128'(bus_if.grant_id), 128'(3));
      tick();
    end
    chk("burst_end_grant", 128'(bus_if.grant), 128'(0));
    chk("burst_expired_pulse", 128'(bus_if.burst_expired), 128'(1));
    tick();
    chk("burst_gap_grant", 128'(bus_if.grant), 128'(0));
    chk("burst_expired_once", 128'(bus_if.burst_expired), 128'(0));
    tick();
    own_cycles(3, 1);
    repeat (3) tick();

    // Master priority while 7 owns, 8 pending
    bus_if.req[7] = 1'b1;
    tick();
    bus_if.req[0]      = 1'b1;
    bus_if.req[8]      = 1'b1;
    bus_if.master_prio = 1'b1;
    next_tenure(7, 2, 1'b0);
    bus_if.master_prio = 1'b0;
    next_tenure(0, 1, 1'b0);
    own_cycles(8, 1);
    repeat (3) tick();

    // Early release by requester 2 after 5 cycles (rr_ptr=9 wraps to reach 2)
    bus_if.req[2] = 1'b1;
    tick();
    own_cycles(2, 5);
    repeat (3) tick();

    // Everyone requests: rr_ptr=3 picks 3, then 4
    bus_if.req = '1;
    tick();
    chk("all_onehot", 128'($onehot(bus_if.grant)), 128'(1));
    next_tenure(3, 1, 1'b0);
    chk("all_next_grant", 128'(bus_if.grant), 128'(oh(4)));

    // Asynchronous reset mid-tenure
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", 128'(bus_if.grant), 128'(0));
    chk("async_rst_id", 128'(bus_if.grant_id), 128'(0));
    chk("async_rst_valid", 128'(bus_if.grant_valid), 128'(0));
    bus_if.req[0] = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_grant", 128'(bus_if.grant), 128'(oh(1)));
    chk("post_rst_id", 128'(bus_if.grant_id), 128'(1));
    bus_if.req = '0;
    repeat (3) tick();

    // Random exclusivity, gap and burst-cap checks
    prev_g    = '0;
    idle_run  = 0;
    run_len   = 0;
    had_grant = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(3) == 0) begin
        k = $urandom_range(NREQ - 1);
        bus_if.req[k] = ~bus_if.req[k];
      end
      if ((c % 16) == 0) bus_if.master_prio = 1'($urandom_range(1));
      tick();
      g      = bus_if.grant;
      exp_id = 0;
      for (int j = 0; j < NREQ; j++) if (g[j]) exp_id = j;
      chk("rnd_onehot0", 128'($onehot0(g)), 128'(1));
      chk("rnd_id", 128'(bus_if.grant_id), 128'(exp_id));
      chk("rnd_valid", 128'(bus_if.grant_valid), 128'(|g));
      if (g != '0) begin
        if (prev_g != '0) begin
          chk("rnd_same_owner", 128'(g), 128'(prev_g));
          run_len++;
        end else begin
          if (had_grant) chk("rnd_gap", 128'(idle_run >= 2), 128'(1));
          run_len   = 1;
          had_grant = 1'b1;
        end
        chk("rnd_burst_cap", 128'(run_len <= 64), 128'(1));
        idle_run = 0;
      end else begin
        idle_run++;
      end
      prev_g = g;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
